// File: rtl/cpu_pkg.sv
// Shared opcodes, state encodings and ALU function codes for the CPU control sequencer.
package cpu_pkg;

  localparam logic [3:0] OP_LOAD   = 4'd0;
  localparam logic [3:0] OP_MOV    = 4'd1;
  localparam logic [3:0] OP_ADD    = 4'd2;
  localparam logic [3:0] OP_SUB    = 4'd3;
  localparam logic [3:0] OP_XOR    = 4'd4;
  localparam logic [3:0] OP_LDPC   = 4'd5;
  localparam logic [3:0] OP_BRANCH = 4'd6;
  localparam logic [3:0] OP_AND    = 4'd7;
  localparam logic [3:0] OP_OR     = 4'd8;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_XOR = 3'd2;
  localparam logic [2:0] ALU_AND = 3'd3;
  localparam logic [2:0] ALU_OR  = 3'd4;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_DECODE = 4'd1,
    ST_LOAD   = 4'd2,
    ST_MOVE   = 4'd3,
    ST_LDPC   = 4'd4,
    ST_BRANCH = 4'd5,
    ST_ALU_A  = 4'd6,
    ST_ALU_X  = 4'd7,
    ST_ALU_W  = 4'd8,
    ST_TRAP   = 4'd9
  } state_e;

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_XOR) ||
           (op == OP_AND) || (op == OP_OR);
  endfunction

  function automatic logic [2:0] alu_func(input logic [3:0] op);
    logic [2:0] f;
    f = ALU_ADD;
    case (op)
      OP_SUB:  f = ALU_SUB;
      OP_XOR:  f = ALU_XOR;
      OP_AND:  f = ALU_AND;
      OP_OR:   f = ALU_OR;
      default: f = ALU_ADD;
    endcase
    return f;
  endfunction

  function automatic logic is_alu_state(input state_e s);
    return (s == ST_ALU_A) || (s == ST_ALU_X) || (s == ST_ALU_W);
  endfunction

endpackage

// File: rtl/seq_alu_counter.sv
// Loadable down-counter timing the ALU execute phase; saturates at zero and
// flags terminal count.
module seq_alu_counter #(
  parameter int ALU_CYCLES = 1
) (
  input  logic clock,
  input  logic resetn,
  input  logic load_i,
  input  logic dec_i,
  output logic zero_o
);

  localparam int CW = (ALU_CYCLES < 1) ? 1 : $clog2(ALU_CYCLES + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(ALU_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/cpu_sequencer.sv
// Registered control sequencer: accepts one instruction, walks a per-opcode
// state sequence and drives datapath strobes. Optional macro: CPU_SEQ_ILLEGAL_TRAP_EN.
//
//   state  | meaning
//   IDLE   | waiting for an instruction, ready when not stalled
//   DECODE | branch on the registered opcode
//   LOAD   | write immediate to register file
//   MOVE   | register-to-register write
//   LDPC   | write register file and load PC
//   BRANCH | load PC
//   ALU_A  | load ALU A operand, arm the execute counter
//   ALU_X  | ALU execute, g_load on terminal count
//   ALU_W  | write ALU result back
//   TRAP   | illegal opcode, held until reset
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int INSTR_W    = 16,
  parameter int ALU_CYCLES = 1
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               new_instr,
  input  logic [INSTR_W-1:0] instr,
  input  logic               stall,
  output logic               ready,
  output logic               done,
  output logic [3:0]         state,
  output logic               ir_load,
  output logic               a_load,
  output logic               g_load,
  output logic               rf_write,
  output logic               pc_load,
  output logic               imm_sel,
  output logic [2:0]         alu_op,
  output logic               illegal
);

  if (INSTR_W < 8) begin : g_bad_instr_w
    $error("cpu_sequencer: INSTR_W must be at least 8");
  end
  if (ALU_CYCLES < 1) begin : g_bad_alu_cycles
    $error("cpu_sequencer: ALU_CYCLES must be at least 1");
  end

  state_e     state_q;
  state_e     state_d;
  logic [3:0] op_q;
  logic [3:0] op_d;
  logic       run;
  logic       cnt_zero;
  logic       accept_r;
  logic       done_r;
  logic       a_load_r;
  logic       g_load_r;
  logic       rf_write_r;
  logic       pc_load_r;
  logic       imm_sel_r;

  // Only the opcode field of the instruction word is consumed here.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr[INSTR_W-5:0];

  assign run = resetn && !stall;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
    end else if (!stall) begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  seq_alu_counter #(
    .ALU_CYCLES(ALU_CYCLES)
  ) u_alu_counter (
    .clock  (clock),
    .resetn (resetn),
    .load_i (run && (state_q == ST_ALU_A)),
    .dec_i  (run && (state_q == ST_ALU_X)),
    .zero_o (cnt_zero)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    accept_r   = 1'b0;
    done_r     = 1'b0;
    a_load_r   = 1'b0;
    g_load_r   = 1'b0;
    rf_write_r = 1'b0;
    pc_load_r  = 1'b0;
    imm_sel_r  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (new_instr) begin
          accept_r = 1'b1;
          op_d     = instr[INSTR_W-1 -: 4];
          state_d  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (op_q == OP_LOAD) begin
          state_d = ST_LOAD;
        end else if (op_q == OP_MOV) begin
          state_d = ST_MOVE;
        end else if (op_q == OP_LDPC) begin
          state_d = ST_LDPC;
        end else if (op_q == OP_BRANCH) begin
          state_d = ST_BRANCH;
        end else if (is_alu_op(op_q)) begin
          state_d = ST_ALU_A;
        end else begin
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
          state_d = ST_TRAP;
`else
          // Illegal opcode retires as a two-cycle NOP.
          done_r  = 1'b1;
          state_d = ST_IDLE;
`endif
        end
      end
      ST_LOAD: begin
        rf_write_r = 1'b1;
        imm_sel_r  = 1'b1;
        done_r     = 1'b1;
        state_d    = ST_IDLE;
      end
      ST_MOVE: begin
        rf_write_r = 1'b1;
        done_r     = 1'b1;
        state_d    = ST_IDLE;
      end
      ST_LDPC: begin
        rf_write_r = 1'b1;
        pc_load_r  = 1'b1;
        done_r     = 1'b1;
        state_d    = ST_IDLE;
      end
      ST_BRANCH: begin
        pc_load_r = 1'b1;
        done_r    = 1'b1;
        state_d   = ST_IDLE;
      end
      ST_ALU_A: begin
        a_load_r = 1'b1;
        state_d  = ST_ALU_X;
      end
      ST_ALU_X: begin
        if (cnt_zero) begin
          g_load_r = 1'b1;
          state_d  = ST_ALU_W;
        end
      end
      ST_ALU_W: begin
        rf_write_r = 1'b1;
        done_r     = 1'b1;
        state_d    = ST_IDLE;
      end
      ST_TRAP: begin
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
        state_d = ST_TRAP;
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobes are suppressed while stalled so they replay exactly once on release.
  assign ready    = run && (state_q == ST_IDLE);
  assign ir_load  = run && accept_r;
  assign done     = run && done_r;
  assign a_load   = run && a_load_r;
  assign g_load   = run && g_load_r;
  assign rf_write = run && rf_write_r;
  assign pc_load  = run && pc_load_r;
  assign imm_sel  = run && imm_sel_r;
  assign state    = resetn ? state_q : ST_IDLE;
  assign alu_op   = (resetn && is_alu_state(state_q)) ? alu_func(op_q) : ALU_ADD;

`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
  assign illegal = resetn && (state_q == ST_TRAP);
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed plus randomized bench for cpu_sequencer against a per-instruction
// trace model (queue of expected cycles per accepted instruction).
module tb_cpu_sequencer;

  localparam int IW = 16;
  localparam int NC = 3;

  logic          clock = 1'b0;
  logic          resetn;
  logic          new_instr;
  logic [IW-1:0] instr;
  logic          stall;
  logic          ready, done, ir_load, a_load, g_load, rf_write, pc_load, imm_sel, illegal;
  logic [3:0]    state;
  logic [2:0]    alu_op;

  always #5 clock = ~clock;

  cpu_sequencer #(.INSTR_W(IW), .ALU_CYCLES(NC)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .new_instr (new_instr),
    .instr     (instr),
    .stall     (stall),
    .ready     (ready),
    .done      (done),
    .state     (state),
    .ir_load   (ir_load),
    .a_load    (a_load),
    .g_load    (g_load),
    .rf_write  (rf_write),
    .pc_load   (pc_load),
    .imm_sel   (imm_sel),
    .alu_op    (alu_op),
    .illegal   (illegal)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       a, g, rf, pc, imm, dn;
    logic [2:0] op;
    logic       trap;
  } step_t;

  step_t sched[$];
  bit    trapped = 1'b0;
  int    tests = 0;
  int    fails = 0;
  int    cyc = 0;
  int    done_seen = 0;
  int    done_exp = 0;

  function automatic step_t mk(input int st, input bit a, g, rf, pc, imm, dn,
                               input int op, input bit trap);
    step_t s;
    s.st = 4'(st); s.a = a; s.g = g; s.rf = rf; s.pc = pc; s.imm = imm; s.dn = dn;
    s.op = 3'(op); s.trap = trap;
    return s;
  endfunction

  // Expected cycle list after the accept cycle, from the opcode table.
  task automatic plan(input logic [3:0] opc);
    int f;
    sched.delete();
    sched.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    case (opc)
      4'd0: sched.push_back(mk(2, 0, 0, 1, 0, 1, 1, 0, 0));
      4'd1: sched.push_back(mk(3, 0, 0, 1, 0, 0, 1, 0, 0));
      4'd5: sched.push_back(mk(4, 0, 0, 1, 1, 0, 1, 0, 0));
      4'd6: sched.push_back(mk(5, 0, 0, 0, 1, 0, 1, 0, 0));
      4'd2, 4'd3, 4'd4, 4'd7, 4'd8: begin
        f = (opc == 4'd2) ? 0 : (opc == 4'd3) ? 1 : (opc == 4'd4) ? 2 : (opc == 4'd7) ? 3 : 4;
        sched.push_back(mk(6, 1, 0, 0, 0, 0, 0, f, 0));
        for (int i = 0; i < NC - 1; i++) sched.push_back(mk(7, 0, 0, 0, 0, 0, 0, f, 0));
        sched.push_back(mk(7, 0, 1, 0, 0, 0, 0, f, 0));
        sched.push_back(mk(8, 0, 0, 1, 0, 0, 1, f, 0));
      end
      default: begin
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
        sched[0].trap = 1'b1;
`else
        sched[0].dn = 1'b1;
`endif
      end
    endcase
  endtask

  function automatic logic [15:0] expected();
    step_t h;
    logic  go;
    go = !stall;
    if (!resetn) return '0;
    if (trapped) return {4'd9, 1'b0, 1'b0, 1'b0, 5'b0, 3'b0, 1'b1};
    if (sched.size() == 0) return {4'd0, go, new_instr && go, 1'b0, 5'b0, 3'b0, 1'b0};
    h = sched[0];
    return {h.st, 1'b0, 1'b0, h.dn && go, h.a && go, h.g && go, h.rf && go,
            h.pc && go, h.imm && go, h.op, 1'b0};
  endfunction

  task automatic cycle(input string tag, input logic rn, input logic st,
                       input logic ni, input logic [IW-1:0] ins);
    logic [15:0] obs;
    logic [15:0] exp_v;
    step_t       s;
    resetn = rn; stall = st; new_instr = ni; instr = ins;
    #1;
    obs   = {state, ready, ir_load, done, a_load, g_load, rf_write, pc_load, imm_sel, alu_op, illegal};
    exp_v = expected();
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp_v);
    end
    if (done === 1'b1) done_seen++;
    if (exp_v[9]) done_exp++;
    @(posedge clock);
    if (!rn) begin
      sched.delete();
      trapped = 1'b0;
    end else if (!st && !trapped) begin
      if (sched.size() == 0) begin
        if (ni) plan(ins[IW-1 -: 4]);
      end else begin
        s = sched.pop_front();
        if (s.trap) trapped = 1'b1;
      end
    end
    cyc++;
    @(negedge clock);
  endtask

  task automatic idle_n(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag, 1'b1, 1'b0, 1'b0, '0);
  endtask

  initial begin
    logic [3:0]    opc;
    logic          rn, st, ni;
    resetn = 1'b0; stall = 1'b0; new_instr = 1'b0; instr = '0;
    @(negedge clock);
    cycle("reset", 1'b0, 1'b0, 1'b1, 16'h0123);
    cycle("reset", 1'b0, 1'b0, 1'b0, '0);

    cycle("load_t0", 1'b1, 1'b0, 1'b1, 16'h0123);
    idle_n("load", 3);

    cycle("add_t0", 1'b1, 1'b0, 1'b1, 16'h2abc);
    idle_n("add", NC + 4);

    cycle("xor_t0", 1'b1, 1'b0, 1'b1, 16'h4000);
    idle_n("xor_pre", 2);
    cycle("xor_stall", 1'b1, 1'b1, 1'b0, '0);
    cycle("xor_stall", 1'b1, 1'b1, 1'b0, '0);
    idle_n("xor_post", NC + 2);

    cycle("ill_t0", 1'b1, 1'b0, 1'b1, 16'hF000);
    for (int i = 0; i < 5; i++) cycle("ill_hold", 1'b1, 1'b0, 1'b1, 16'h0123);
    cycle("ill_rst", 1'b0, 1'b0, 1'b0, '0);
    idle_n("ill_after", 2);

    cycle("rst_alu_t0", 1'b1, 1'b0, 1'b1, 16'h3000);
    idle_n("rst_alu", 3);
    cycle("rst_alu_low", 1'b0, 1'b0, 1'b1, 16'h1000);
    cycle("rst_alu_low", 1'b0, 1'b0, 1'b0, '0);
    idle_n("rst_alu_rel", 2);

    cycle("idle_stall", 1'b1, 1'b1, 1'b1, 16'h6000);
    cycle("idle_stall", 1'b1, 1'b1, 1'b1, 16'h6000);
    cycle("stall_drop", 1'b1, 1'b0, 1'b1, 16'h6000);
    idle_n("branch", 3);

    cycle("b2b_t0", 1'b1, 1'b0, 1'b1, 16'h5000);
    cycle("b2b", 1'b1, 1'b0, 1'b1, 16'h7000);
    cycle("b2b", 1'b1, 1'b0, 1'b1, 16'h8000);
    for (int i = 0; i < NC + 6; i++) cycle("b2b", 1'b1, 1'b0, 1'b1, 16'h8000);
    idle_n("b2b_end", NC + 4);

    for (int i = 0; i < 600; i++) begin
      rn  = ($urandom_range(0, 99) >= 3);
      st  = ($urandom_range(0, 99) < 20);
      ni  = ($urandom_range(0, 99) < 60);
      opc = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      cycle("rand", rn, st, ni, {opc, 12'($urandom)});
    end

    tests++;
    assert (done_seen == done_exp) else begin
      fails++;
      $error("FAIL done_count observed=%0d expected=%0d", done_seen, done_exp);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
